// File: rtl/cplx_pkg.sv
// Shared types and helpers for the complex datapath blocks.
// Padded AXIS widths, accumulator sizing, rounding modes, saturation.
package cplx_pkg;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;
  localparam int SAT_MAX_W   = 128;

  function automatic int axis_w(input int w);
    return ((w * 2 + 15) / 16) * 16;
  endfunction

  function automatic int acc_w(
    input int iw,
    input int len_log2
  );
    return iw + len_log2;
  endfunction

  // {below signed ow-bit min, above signed ow-bit max}
  function automatic logic [1:0] sat_flags(
    input logic signed [SAT_MAX_W-1:0] v,
    input int                          ow
  );
    logic signed [SAT_MAX_W-1:0] one;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    one = SAT_MAX_W'(1);
    hi  = (one <<< (ow - 1)) - one;
    lo  = -(one <<< (ow - 1));
    return {v < lo, v > hi};
  endfunction

endpackage

// File: rtl/complex_accumulator_if.sv
// AXI-Stream style bundle between the accumulator and its neighbours.
// slave is the accumulator side, master is the producer/consumer side.
interface complex_accumulator_if
  import cplx_pkg::*;
#(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 32,
  parameter int LEN_LOG2     = 10
);
  localparam int IN_W  = axis_w(INPUT_WIDTH);
  localparam int OUT_W = axis_w(OUTPUT_WIDTH);

  logic [LEN_LOG2-1:0] acc_length;
  logic [IN_W-1:0]     s_axis_in_tdata;
  logic                s_axis_in_tvalid;
  logic                s_axis_in_tready;
  logic [OUT_W-1:0]    m_axis_dout_tdata;
  logic                m_axis_dout_tvalid;
  logic                m_axis_dout_tready;
  logic [1:0]          m_axis_dout_tuser;

  modport master (
    output acc_length,
    output s_axis_in_tdata,
    output s_axis_in_tvalid,
    input  s_axis_in_tready,
    input  m_axis_dout_tdata,
    input  m_axis_dout_tvalid,
    output m_axis_dout_tready,
    input  m_axis_dout_tuser
  );

  modport slave (
    input  acc_length,
    input  s_axis_in_tdata,
    input  s_axis_in_tvalid,
    output s_axis_in_tready,
    output m_axis_dout_tdata,
    output m_axis_dout_tvalid,
    input  m_axis_dout_tready,
    output m_axis_dout_tuser
  );

endinterface

// File: rtl/cplx_round_sat.sv
// Round, arithmetic shift and saturate for one signed component.
// Sum is widened by one bit so the rounding constant cannot wrap.
module cplx_round_sat
  import cplx_pkg::*;
#(
  parameter int ACC_W        = 42,
  parameter int OUTPUT_WIDTH = 32,
  parameter int OUTPUT_SHIFT = 10,
  parameter int ROUND_MODE   = 0
) (
  input  logic signed [ACC_W-1:0]        i_sum,
  output logic signed [OUTPUT_WIDTH-1:0] o_val,
  output logic                           o_clip
);

  localparam int RND_SH =
    (OUTPUT_SHIFT > 0) ? OUTPUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (ROUND_MODE == RND_HALF_UP && OUTPUT_SHIFT > 0)
      ? ((ACC_W + 1)'(1) << RND_SH) : '0;
  localparam logic signed [OUTPUT_WIDTH-1:0] MAX_V =
    {1'b0, {(OUTPUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUTPUT_WIDTH-1:0] MIN_V =
    {1'b1, {(OUTPUT_WIDTH - 1){1'b0}}};

  logic signed [ACC_W:0]       w_ext;
  logic signed [ACC_W:0]       w_shift;
  logic signed [SAT_MAX_W-1:0] w_wide;
  logic [1:0]                  w_sat;

  assign w_ext   = {i_sum[ACC_W-1], i_sum};
  assign w_shift = (w_ext + RND) >>> OUTPUT_SHIFT;
  assign w_wide  = SAT_MAX_W'(w_shift);
  assign w_sat   = sat_flags(w_wide, OUTPUT_WIDTH);
  assign o_clip  = |w_sat;

  // clamp to the output range when the shifted sum falls outside it
  always_comb begin
    o_val = w_wide[OUTPUT_WIDTH-1:0];
    unique case (1'b1)
      w_sat[1]: o_val = MIN_V;
      w_sat[0]: o_val = MAX_V;
      default:  ;
    endcase
  end

endmodule

// File: rtl/complex_accumulator.sv
// Complex integrate-and-dump: sums len products, emits scaled sum.
// Stage A holds the raw frame sum, stage B the rounded/saturated output.
module complex_accumulator
  import cplx_pkg::*;
#(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 32,
  parameter int LEN_LOG2     = 10,
  parameter int OUTPUT_SHIFT = 10,
  parameter int ROUND_MODE   = 0
) (
  input logic                  aclk,
  input logic                  areset,
  complex_accumulator_if.slave bus
);

  localparam int IN_W  = axis_w(INPUT_WIDTH);
  localparam int OUT_W = axis_w(OUTPUT_WIDTH);
  localparam int ACC_W = acc_w(INPUT_WIDTH, LEN_LOG2);
  localparam int HALF  = OUT_W / 2;

  logic signed [INPUT_WIDTH-1:0]  w_in_re;
  logic signed [INPUT_WIDTH-1:0]  w_in_im;
  logic signed [ACC_W-1:0]        w_sum_re;
  logic signed [ACC_W-1:0]        w_sum_im;
  logic signed [ACC_W-1:0]        r_acc_re;
  logic signed [ACC_W-1:0]        r_acc_im;
  logic signed [ACC_W-1:0]        r_dump_re;
  logic signed [ACC_W-1:0]        r_dump_im;
  logic [LEN_LOG2-1:0]            r_count;
  logic [LEN_LOG2-1:0]            r_len;
  logic [LEN_LOG2-1:0]            w_len;
  logic                           r_dump_valid;
  logic                           w_ready;
  logic                           w_accept;
  logic                           w_last;
  logic                           w_b_load;
  logic signed [OUTPUT_WIDTH-1:0] w_out_re;
  logic signed [OUTPUT_WIDTH-1:0] w_out_im;
  logic                           w_clip_re;
  logic                           w_clip_im;
  logic [OUT_W-1:0]               r_out_data;
  logic                           r_out_valid;
  logic [1:0]                     r_out_user;

  assign w_in_re = bus.s_axis_in_tdata[INPUT_WIDTH-1:0];
  assign w_in_im = bus.s_axis_in_tdata[IN_W/2 +: INPUT_WIDTH];

  assign w_ready  = !(r_dump_valid && r_out_valid &&
                      !bus.m_axis_dout_tready);
  assign w_accept = bus.s_axis_in_tvalid && w_ready;
  assign w_b_load = r_dump_valid &&
                    (!r_out_valid || bus.m_axis_dout_tready);

  assign w_len = (r_count != '0) ? r_len :
                 (bus.acc_length == '0) ? LEN_LOG2'(1) :
                 bus.acc_length;
  assign w_last = w_accept &&
                  (r_count == w_len - LEN_LOG2'(1));

  assign w_sum_re = r_acc_re + ACC_W'(w_in_re);
  assign w_sum_im = r_acc_im + ACC_W'(w_in_im);

  assign bus.s_axis_in_tready   = w_ready;
  assign bus.m_axis_dout_tdata  = r_out_data;
  assign bus.m_axis_dout_tvalid = r_out_valid;
  assign bus.m_axis_dout_tuser  = r_out_user;

  // integrate samples; clear on the last one so frames abut
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_count  <= '0;
      r_len    <= '0;
    end else if (w_accept) begin
      if (r_count == '0) r_len <= w_len;
      if (w_last) begin
        r_acc_re <= '0;
        r_acc_im <= '0;
        r_count  <= '0;
      end else begin
        r_acc_re <= w_sum_re;
        r_acc_im <= w_sum_im;
        r_count  <= r_count + LEN_LOG2'(1);
      end
    end
  end

  // stage A: raw frame sum, overwritten if B takes the old one
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_dump_re    <= '0;
      r_dump_im    <= '0;
      r_dump_valid <= 1'b0;
    end else if (w_last) begin
      r_dump_re    <= w_sum_re;
      r_dump_im    <= w_sum_im;
      r_dump_valid <= 1'b1;
    end else if (w_b_load) begin
      r_dump_valid <= 1'b0;
    end
  end

  cplx_round_sat #(
    .ACC_W        (ACC_W),
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .OUTPUT_SHIFT (OUTPUT_SHIFT),
    .ROUND_MODE   (ROUND_MODE)
  ) u_rs_re (
    .i_sum  (r_dump_re),
    .o_val  (w_out_re),
    .o_clip (w_clip_re)
  );

  cplx_round_sat #(
    .ACC_W        (ACC_W),
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .OUTPUT_SHIFT (OUTPUT_SHIFT),
    .ROUND_MODE   (ROUND_MODE)
  ) u_rs_im (
    .i_sum  (r_dump_im),
    .o_val  (w_out_im),
    .o_clip (w_clip_im)
  );

  // stage B: output register, held until the consumer accepts
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_user  <= '0;
    end else if (w_b_load) begin
      r_out_data  <= {HALF'(w_out_im), HALF'(w_out_re)};
      r_out_valid <= 1'b1;
      r_out_user  <= {w_clip_im, w_clip_re};
    end else if (bus.m_axis_dout_tready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
